// File: rtl/irq_controller_pkg.sv
// Shared definitions for the interrupt controller: FSM encodings,
// the "no vector" value and the source-count limit.
package irq_controller_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } irq_state_t;

    localparam logic [7:0] IRQ_VEC_NONE = 8'h00;
    localparam int         IRQ_MAX_SRC  = 8;

    // Width of a source index; at least one bit even for a single source.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/irq_prio_encoder.sv
// Priority search over the eligible sources, starting at a given index
// and wrapping at NUM_SRC; reports the first hit and whether one exists.
module irq_prio_encoder
    import irq_controller_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int IW      = idx_w(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] eligible,
    input  logic [IW-1:0]      start,
    output logic [IW-1:0]      grant,
    output logic               valid
);

    int idx;

    // Walk the sources from start upward, first eligible one wins.
    always_comb begin
        grant = '0;
        valid = 1'b0;
        idx   = 0;
        for (int k = 0; k < NUM_SRC; k++) begin
            idx = (int'(start) + k) % NUM_SRC;
            if (!valid && eligible[idx]) begin
                valid = 1'b1;
                grant = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/irq_controller.sv
// Interrupt controller: edge-detected pending latch, mask, priority grant
// and req/ack/eoi handshake. Define IRQ_ROTATE_EN for rotating priority.
module irq_controller
    import irq_controller_pkg::*;
#(
    parameter int         NUM_SRC  = 4,
    parameter logic [7:0] VEC_BASE = 8'h10
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] irq,
    input  logic               mask_wr,
    input  logic [7:0]         mask_data,
    input  logic               ack,
    input  logic               eoi,
    output logic               int_out,
    output logic [7:0]         vector,
    output logic [NUM_SRC-1:0] pending,
    output logic               busy
);

    localparam int IW = idx_w(NUM_SRC);

    irq_state_t         state;
    logic [NUM_SRC-1:0] irq_q;
    logic [NUM_SRC-1:0] mask;
    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] eligible;
    logic [NUM_SRC-1:0] clr;
    logic [NUM_SRC-1:0] pending_nxt;
    logic [IW-1:0]      start;
    logic [IW-1:0]      grant;
    logic               valid;
    logic               take;
    logic               unused_mask;

    // Mask bits above the implemented sources are don't-care.
    assign unused_mask = ^mask_data;

    assign rise     = irq & ~irq_q;
    assign eligible = pending & ~mask;
    assign take     = (state == REQ) && ack && valid;

    irq_prio_encoder #(
        .NUM_SRC (NUM_SRC),
        .IW      (IW)
    ) u_prio (
        .eligible (eligible),
        .start    (start),
        .grant    (grant),
        .valid    (valid)
    );

`ifdef IRQ_ROTATE_EN
    logic [IW-1:0] last_served;

    assign start = (last_served == IW'(NUM_SRC - 1)) ?
                   '0 : last_served + 1'b1;

    // Remember the most recently granted source for round-robin search.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_served <= '0;
        end else if (take) begin
            last_served <= grant;
        end
    end
`else
    assign start = '0;
`endif

    // Clear the granted bit; a fresh edge on the same bit still sets it.
    always_comb begin
        clr = '0;
        if (take) begin
            clr[grant] = 1'b1;
        end
        pending_nxt = (pending & ~clr) | rise;
    end

    // Edge detect, pending/mask registers and the handshake FSM.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            irq_q   <= '0;
            pending <= '0;
            mask    <= '1;
            int_out <= 1'b0;
            vector  <= IRQ_VEC_NONE;
            busy    <= 1'b0;
        end else begin
            irq_q   <= irq;
            pending <= pending_nxt;
            if (mask_wr) begin
                mask <= mask_data[NUM_SRC-1:0];
            end
            unique case (state)
                IDLE: begin
                    int_out <= 1'b0;
                    if (eligible != '0) begin
                        state   <= REQ;
                        int_out <= 1'b1;
                    end
                end
                REQ: begin
                    if (take) begin
                        state   <= SERVICE;
                        int_out <= 1'b0;
                        vector  <= VEC_BASE + 8'(grant);
                        busy    <= 1'b1;
                    end else if (!valid) begin
                        state   <= IDLE;
                        int_out <= 1'b0;
                    end
                end
                SERVICE: begin
                    int_out <= 1'b0;
                    if (eoi) begin
                        state  <= IDLE;
                        vector <= IRQ_VEC_NONE;
                        busy   <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    int_out <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller: vector table for the handshake
// scenarios plus a hand-written asynchronous reset sequence.
module tb_irq_controller;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] irq;
    logic       mask_wr;
    logic [7:0] mask_data;
    logic       ack;
    logic       eoi;
    logic       int_out, int_out2;
    logic [7:0] vector, vector2;
    logic [3:0] pending, pending2;
    logic       busy, busy2;

    int npass = 0;
    int ntotal = 0;

    typedef struct {
        logic [3:0] irq;
        logic       mw;
        logic [7:0] md;
        logic       ack;
        logic       eoi;
        logic       e_int;
        logic [7:0] e_vec;
        logic [3:0] e_pend;
        logic       e_busy;
    } vec_t;

    vec_t tbl[$];

    irq_controller #(.NUM_SRC(4), .VEC_BASE(8'h10)) dut (
        .clock     (clock),
        .reset     (reset),
        .irq       (irq),
        .mask_wr   (mask_wr),
        .mask_data (mask_data),
        .ack       (ack),
        .eoi       (eoi),
        .int_out   (int_out),
        .vector    (vector),
        .pending   (pending),
        .busy      (busy)
    );

    irq_controller #(.NUM_SRC(4), .VEC_BASE(8'hFE)) dut_wrap (
        .clock     (clock),
        .reset     (reset),
        .irq       (irq),
        .mask_wr   (mask_wr),
        .mask_data (mask_data),
        .ack       (ack),
        .eoi       (eoi),
        .int_out   (int_out2),
        .vector    (vector2),
        .pending   (pending2),
        .busy      (busy2)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input int step,
                       input logic [7:0] act, input logic [7:0] exp);
        ntotal++;
        if (act === exp) begin
            npass++;
        end else begin
            $display("FAIL %s step %0d: got %0h expected %0h",
                     nm, step, act, exp);
        end
    endtask

    task automatic add(input logic [3:0] i, input logic mw,
                       input logic [7:0] md, input logic a,
                       input logic e, input logic ei,
                       input logic [7:0] ev, input logic [3:0] ep,
                       input logic eb);
        vec_t v;
        v.irq = i; v.mw = mw; v.md = md; v.ack = a; v.eoi = e;
        v.e_int = ei; v.e_vec = ev; v.e_pend = ep; v.e_busy = eb;
        tbl.push_back(v);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_all(input int step, input logic ei,
                             input logic [7:0] ev, input logic [3:0] ep,
                             input logic eb);
        logic [7:0] ev2;
        ev2 = (ev == 8'h00) ? 8'h00 : ev + 8'hEE;
        chk("int_out", step, {7'd0, int_out}, {7'd0, ei});
        chk("vector",  step, vector, ev);
        chk("pending", step, {4'd0, pending}, {4'd0, ep});
        chk("busy",    step, {7'd0, busy}, {7'd0, eb});
        chk("vec_wrap", step, vector2, ev2);
    endtask

    initial begin
        reset = 1'b1;
        irq = '0; mask_wr = 0; mask_data = 8'h00; ack = 0; eoi = 0;
        repeat (2) tick();
        check_all(-1, 0, 8'h00, 4'h0, 0);
        reset = 1'b0;

        //  irq   mw md    ack eoi  int vec    pend  busy
        // basic source 2 handshake
        add(4'h0, 1, 8'h00, 0, 0,  0, 8'h00, 4'h0, 0);
        add(4'h4, 0, 8'h00, 0, 0,  0, 8'h00, 4'h4, 0);
        add(4'h4, 0, 8'h00, 0, 0,  1, 8'h00, 4'h4, 0);
        add(4'h0, 0, 8'h00, 1, 0,  0, 8'h12, 4'h0, 1);
        add(4'h0, 0, 8'h00, 0, 0,  0, 8'h12, 4'h0, 1);
        add(4'h0, 0, 8'h00, 0, 1,  0, 8'h00, 4'h0, 0);
        // simultaneous sources 3 and 1
        add(4'hA, 0, 8'h00, 0, 0,  0, 8'h00, 4'hA, 0);
        add(4'h0, 0, 8'h00, 0, 0,  1, 8'h00, 4'hA, 0);
        add(4'h0, 0, 8'h00, 1, 0,  0, 8'h11, 4'h8, 1);
        add(4'h0, 0, 8'h00, 0, 1,  0, 8'h00, 4'h8, 0);
        add(4'h0, 0, 8'h00, 0, 0,  1, 8'h00, 4'h8, 0);
        add(4'h0, 0, 8'h00, 1, 0,  0, 8'h13, 4'h0, 1);
        add(4'h0, 0, 8'h00, 1, 1,  0, 8'h00, 4'h0, 0);
        add(4'h0, 0, 8'h00, 1, 0,  0, 8'h00, 4'h0, 0);
        // masking
        add(4'h0, 1, 8'h01, 0, 0,  0, 8'h00, 4'h0, 0);
        add(4'h1, 0, 8'h00, 0, 0,  0, 8'h00, 4'h1, 0);
        add(4'h0, 0, 8'h00, 0, 0,  0, 8'h00, 4'h1, 0);
        add(4'h0, 1, 8'h00, 0, 0,  0, 8'h00, 4'h1, 0);
        add(4'h0, 0, 8'h00, 0, 0,  1, 8'h00, 4'h1, 0);
        add(4'h0, 1, 8'h01, 0, 0,  1, 8'h00, 4'h1, 0);
        add(4'h0, 0, 8'h00, 0, 0,  0, 8'h00, 4'h1, 0);
        add(4'h0, 1, 8'hF0, 0, 0,  0, 8'h00, 4'h1, 0);
        add(4'h0, 0, 8'h00, 0, 0,  1, 8'h00, 4'h1, 0);
        add(4'h0, 0, 8'h00, 1, 0,  0, 8'h10, 4'h0, 1);
        add(4'h0, 0, 8'h00, 0, 1,  0, 8'h00, 4'h0, 0);
        // re-rise of source 2 in the ack cycle
        add(4'h4, 0, 8'h00, 0, 0,  0, 8'h00, 4'h4, 0);
        add(4'h0, 0, 8'h00, 0, 0,  1, 8'h00, 4'h4, 0);
        add(4'h4, 0, 8'h00, 1, 0,  0, 8'h12, 4'h4, 1);
        add(4'h0, 0, 8'h00, 0, 0,  0, 8'h12, 4'h4, 1);
        add(4'h0, 0, 8'h00, 0, 1,  0, 8'h00, 4'h4, 0);
        add(4'h0, 0, 8'h00, 0, 0,  1, 8'h00, 4'h4, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            irq = tbl[i].irq;
            mask_wr = tbl[i].mw;
            mask_data = tbl[i].md;
            ack = tbl[i].ack;
            eoi = tbl[i].eoi;
            tick();
            check_all(i, tbl[i].e_int, tbl[i].e_vec,
                      tbl[i].e_pend, tbl[i].e_busy);
        end

        // reset in SERVICE: enter service on source 2, add pending 1
        irq = 4'h0; mask_wr = 0; eoi = 0; ack = 1;
        tick();
        check_all(100, 0, 8'h12, 4'h0, 1);
        ack = 0; irq = 4'h2;
        tick();
        check_all(101, 0, 8'h12, 4'h2, 1);
        irq = 4'h0;
        #2;
        reset = 1'b1;
        #1;
        check_all(102, 0, 8'h00, 4'h0, 0);
        // events during reset are lost
        irq = 4'h1;
        tick();
        irq = 4'h0;
        tick();
        reset = 1'b0;
        ack = 1; eoi = 1;
        tick();
        check_all(103, 0, 8'h00, 4'h0, 0);
        ack = 0; eoi = 0;
        mask_wr = 1; mask_data = 8'h00;
        tick();
        mask_wr = 0;
        repeat (2) tick();
        check_all(104, 0, 8'h00, 4'h0, 0);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
